// File: rtl/test_checker.sv
// Streaming result checker: compares DUT words against expected words over a
// fixed-length run and reports sticky pass/fail with a no-progress watchdog.
module test_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 64,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dut_valid,
  input  logic [DATA_WIDTH-1:0] dut_data,
  output logic                  dut_ready,
  input  logic                  exp_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  exp_ready,
  output logic                  pass,
  output logic                  fail,
  output logic                  busy,
  output logic [15:0]           err_count,
  output logic [15:0]           cmp_count,
  output logic                  timed_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The idle counter only ever needs to hold TIMEOUT-1: the cycle that would
  // reach TIMEOUT ends the run instead of incrementing.
  localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [15:0]       CMP_LAST  = 16'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                hs;
  logic                mismatch;
  logic                clear;
  logic                finish;
  logic                timeout_hit;

  assign hs        = (state_q == RUN) && dut_valid && exp_valid;
  assign mismatch  = (dut_data != exp_data);
  assign dut_ready = hs;
  assign exp_ready = hs;
  assign busy      = (state_q == RUN);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    clear       = 1'b0;
    finish      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        // A handshake always wins over the watchdog on the same cycle.
        if (hs) begin
          if (cmp_count == CMP_LAST) begin
            state_d = DONE;
            finish  = 1'b1;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          state_d     = DONE;
          timeout_hit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, and reset is
  // sampled on the clock edge, so it also overrides a same-cycle start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idle_cnt  <= '0;
      err_count <= '0;
      cmp_count <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        idle_cnt  <= '0;
        err_count <= '0;
        cmp_count <= '0;
        pass      <= 1'b0;
        fail      <= 1'b0;
        timed_out <= 1'b0;
      end else if (hs) begin
        idle_cnt  <= '0;
        cmp_count <= cmp_count + 16'd1;
        if (mismatch && (err_count != 16'hFFFF))
          err_count <= err_count + 16'd1;
        if (finish) begin
          if ((err_count == 16'd0) && !mismatch) pass <= 1'b1;
          else                                   fail <= 1'b1;
        end
      end else if (timeout_hit) begin
        fail      <= 1'b1;
        timed_out <= 1'b1;
      end else if (state_q == RUN) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/test_checker.md
TEST_CHECKER -- requirements
Module: test_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of compared words.
REQ-002 SHALL have parameter NUM_WORDS, default 64, number of comparisons required for pass.
REQ-003 SHALL have parameter TIMEOUT, default 1000, maximum idle cycles between consecutive comparisons.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a test run.
REQ-007 SHALL have port dut_valid  input  1  DUT output word valid.
REQ-008 SHALL have port dut_data  input  DATA_WIDTH  DUT output word.
REQ-009 SHALL have port dut_ready  output  1  checker accepts DUT word.
REQ-010 SHALL have port exp_valid  input  1  expected word valid.
REQ-011 SHALL have port exp_data  input  DATA_WIDTH  expected word.
REQ-012 SHALL have port exp_ready  output  1  checker accepts expected word.
REQ-013 SHALL have port pass  output  1  sticky test-passed flag, feeds status reporter.
REQ-014 SHALL have port fail  output  1  sticky test-failed flag, feeds status reporter.
REQ-015 SHALL have port busy  output  1  high while in RUN.
REQ-016 SHALL have port err_count  output  16  number of mismatched comparisons, saturating at 16'hFFFF.
REQ-017 SHALL have port cmp_count  output  16  number of comparisons done this run.
REQ-018 SHALL have port timed_out  output  1  sticky, set when failure cause is watchdog.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE.
REQ-020 IDLE: start=1 -> RUN next cycle; cmp_count, err_count, idle counter, pass, fail, timed_out cleared on that edge.
REQ-021 RUN: dut_ready = exp_ready = (dut_valid & exp_valid); one comparison per cycle when both valid (handshake fires).
REQ-022 A comparison SHALL increment cmp_count; if dut_data != exp_data, err_count increments (saturating).
REQ-023 Idle counter SHALL increment each RUN cycle without a handshake and clear on each handshake.
REQ-024 RUN -> DONE on the edge where the NUM_WORDS-th handshake fires; pass=1 if err_count including this comparison is 0, else fail=1; pass and fail never both 1.
REQ-025 RUN -> DONE with fail=1, timed_out=1 when idle counter reaches TIMEOUT with no handshake that cycle; handshake on same cycle takes precedence and clears counter.
REQ-026 DONE: pass/fail held; dut_ready, exp_ready = 0; start=1 restarts exactly as in IDLE (flags clear, enter RUN).
REQ-027 start while in RUN SHALL be ignored.
REQ-028 Outside RUN, dut_ready and exp_ready SHALL be 0; input words are not consumed.
REQ-029 busy = 1 only in RUN; pass/fail/timed_out change only on RUN->DONE or start-clear edges.
REQ-030 Comparison latency SHALL be one cycle: flags/counters reflect a handshake on the following clock edge.

Reset
REQ-031 reset=0 at a rising edge SHALL force state IDLE, pass=0, fail=0, timed_out=0, busy=0, dut_ready=0, exp_ready=0, err_count=0, cmp_count=0, idle counter=0.
REQ-032 reset asserted mid-RUN SHALL abort the run with no pass/fail indication; reset overrides start on the same edge.

Verification
REQ-033 NUM_WORDS=4: start, four matching word pairs back-to-back -> pass=1 the edge after 4th handshake, cmp_count=4, err_count=0, fail=0.
REQ-034 NUM_WORDS=4: pair 2 dut_data=16'h0001 vs exp_data=16'h0002 -> after 4th handshake fail=1, err_count=1, pass=0, timed_out=0.
REQ-035 TIMEOUT=10: start, exp_valid=1, dut_valid held 0 -> fail=1, timed_out=1 after 10 RUN cycles; ready outputs stay 0 throughout.
REQ-036 Stall: dut_valid toggling every other cycle with TIMEOUT=10 -> no timeout, pass=1 after NUM_WORDS handshakes.
REQ-037 reset=0 for one cycle after 2 handshakes -> all outputs 0, state IDLE; subsequent start runs full test from cmp_count=0.
REQ-038 start pulsed in DONE after fail -> fail cleared, busy=1 next cycle, new run passes with matching data.
